fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch initiator for the instruction memory. Owns the PC.
//   Drives a byte address to the combinational imem, captures the returned
//   word into a small prefetch queue, and hands {pc, instr} to decode over a
//   valid/ready handshake. Accepts branch/jump redirects from later stages
//   and flags illegal fetch addresses.
// PARAMETERS
//   BASE_ADDR  32'h0000_3000  reset PC; first byte address of the imem window
//   IM_WORDS   4096           imem size in 32-bit words; legal window is [BASE_ADDR, BASE_ADDR+4*IM_WORDS)
//   QDEPTH     2              prefetch queue entries (power of 2, >=2)
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-low reset
//   imem_pc        out  32  byte address presented to imem (= PC register)
//   imem_instr     in   32  imem read data; combinational from imem_pc, same cycle
//   if_valid       out  1   queue head holds a valid instruction
//   if_ready       in   1   decode accepts head this cycle
//   if_pc          out  32  byte PC of head entry
//   if_instr       out  32  instruction word of head entry
//   redirect_valid in   1   control transfer: restart fetch at redirect_pc
//   redirect_pc    in   32  target byte address
//   fetch_fault    out  1   sticky: illegal fetch address, fetching halted
// BEHAVIOUR
//   Reset (async assert, sync-safe release): PC=BASE_ADDR, queue empty,
//     state=RUN, if_valid=0, if_pc=0, if_instr=0, fetch_fault=0.
//   legal(a) = a[1:0]==0 && a>=BASE_ADDR && a-BASE_ADDR < 4*IM_WORDS (33-bit compare, no wrap).
//   States: RUN (fetching), FAULT (halted). fetch_fault = (state==FAULT).
//   pop  = if_valid & if_ready.
//   push = state==RUN & !redirect_valid & legal(PC) & (count<QDEPTH | pop).
//   On push: write {PC, imem_instr} at tail; PC <= PC+4. Otherwise PC holds.
//   Latency: word fetched at edge N appears on if_* after edge N (1 cycle).
//     After reset release: imem_pc=BASE_ADDR; if_valid=1 after first edge.
//   Full queue with pop in same cycle: push and pop both occur, count unchanged.
//   Empty queue: if_valid=0; if_pc/if_instr hold last head value (don't-care).
//   RUN & !legal(PC) & !redirect_valid: no push; state -> FAULT at edge.
//     Already-queued entries still drain normally.
//   Redirect (highest priority, any state): queue cleared, PC <= redirect_pc,
//     no push. A coincident pop is a completed handshake. Next state = RUN if
//     legal(redirect_pc) else FAULT. Only a legal redirect leaves FAULT.
//   PC arithmetic modulo 2^32; end of window is caught by legal(), not wrap.
//   if_* driven from registered queue storage; no comb path imem_instr -> if_*.
//   Reset asserted mid-operation: all state returns to reset values immediately.
// STRUCTURE
//   Shared package cpu_defs: BASE_ADDR default, INSTR_W=32, PC_W=32,
//     fetch state encoding (FS_RUN, FS_FAULT).
//   Sub-module fetch_queue: QDEPTH-entry FIFO of {pc,instr} with push/pop/
//     clear, count, head outputs; supports simultaneous push+pop when full.
//   Top: PC register, legality check, state register, push/redirect control.
// TESTING
//   Reset, if_ready=1, imem preloaded 0x3000..0x300C -> if_pc 0x3000,0x3004,
//     0x3008,0x300C on consecutive cycles from cycle 1; if_instr matches.
//   if_ready=0 for 5 cycles -> imem_pc stops at 0x3008 (2 queued), if_valid
//     held with if_pc=0x3000; if_ready=1 -> stream resumes, nothing lost/duplicated.
//   Redirect to 0x3040 while 2 entries queued and pop active -> head consumed,
//     other dropped; next if_pc=0x3040 one cycle later.
//   Redirect to 0x3042 -> fetch_fault=1 next cycle, if_valid=0, imem_pc holds;
//     redirect to 0x3000 -> fault clears, fetch resumes at 0x3000.
//   Redirect to BASE_ADDR+4*IM_WORDS-8 -> two words delivered, then
//     fetch_fault=1, no further if_valid.
//   Assert reset low mid-stream with full queue -> immediately if_valid=0,
//     imem_pc=0x3000; after release, fetch restarts from 0x3000.

Source files
------------

// File: rtl/cpu_defs.sv
// ---------------------------------------------------------------------------
// cpu_defs: definitions shared by the instruction-fetch slice.
//   - datapath widths (PC_W, INSTR_W) and the width of one queued entry
//   - default reset PC / start of the instruction-memory window
//   - fetch FSM state encoding (FS_RUN, FS_FAULT)
//   - addr_legal(): fetch-address legality check against the imem window
// ---------------------------------------------------------------------------
package cpu_defs;

  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  // One prefetch entry is {pc, instr}; pc lives in the upper half.
  localparam int ENTRY_W = PC_W + INSTR_W;

  localparam logic [PC_W-1:0] BASE_ADDR_DEFAULT = 32'h0000_3000;

  typedef enum logic {
    FS_RUN   = 1'b0,  // fetching sequentially
    FS_FAULT = 1'b1   // halted on an illegal fetch address
  } fetch_state_e;

  // An address is fetchable when it is word aligned and falls inside
  // [base, base + window_bytes). The offset is computed in 33 bits so a
  // window that ends at or beyond 2^32 cannot wrap into a false "legal".
  function automatic logic addr_legal(
    input logic [PC_W-1:0] addr,
    input logic [PC_W-1:0] base,
    input logic [PC_W:0]   window_bytes
  );
    logic [PC_W:0] offset;
    offset = {1'b0, addr} - {1'b0, base};
    return (addr[1:0] == 2'b00) && (addr >= base) && (offset < window_bytes);
  endfunction

endpackage : cpu_defs

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue: DEPTH-entry FIFO of {pc, instr} prefetch entries.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   drop every entry (wins over push and pop)
//   push       in   write push_data at the tail
//   push_data  in   {pc, instr} entry to enqueue
//   pop        in   retire the head entry
//   count      out  number of valid entries (0..DEPTH)
//   head_valid out  count != 0
//   head_data  out  {pc, instr} of the head entry, straight from storage
//
// A push into a full queue is taken only when a pop happens in the same
// cycle; the written slot is then the one being vacated by that pop, which
// is safe because the head is read from storage before the edge.
// When empty, head_data shows whatever the read slot last held.
// ---------------------------------------------------------------------------
module fetch_queue
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [ENTRY_W-1:0]       head_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               pop_eff;
  logic               push_eff;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    // Guard against popping an empty queue or overfilling it; the top
    // already respects these, so they only matter for misuse.
    pop_eff  = pop && (count_q != '0);
    push_eff = push && ((count_q != CW'(DEPTH)) || pop_eff);

    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head_data  = mem_q[rd_ptr_q];

endmodule : fetch_queue

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit: instruction-fetch initiator. Owns the PC, presents it to a
// combinational imem, captures {pc, instr} into a small prefetch queue and
// hands the queue head to decode. Accepts redirects from later stages and
// halts with a sticky fault on an illegal fetch address.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   imem_pc        out  byte address to imem (the PC register)
//   imem_instr     in   imem read data for imem_pc, same cycle
//   if_valid       out  queue head holds an instruction
//   if_ready       in   decode takes the head this cycle
//   if_pc          out  byte PC of the head entry
//   if_instr       out  instruction word of the head entry
//   redirect_valid in   restart fetch at redirect_pc
//   redirect_pc    in   redirect target byte address
//   fetch_fault    out  halted on an illegal fetch address (registered)
//   dbg_state      out  raw fetch FSM state (FS_RUN / FS_FAULT)
//
// Decode handshake: an entry transfers on every rising edge where
// if_valid && if_ready. if_valid never depends on if_ready, if_pc/if_instr
// are stable while if_valid is high and not yet accepted, and they come
// straight from queue storage (no path from imem_instr to if_*).
//
// Redirect has priority over everything: it clears the queue, loads the PC
// and suppresses the fetch for that cycle. A head accepted in the same
// cycle still counts as delivered. Only a legal redirect target leaves
// FS_FAULT; an illegal one enters it.
// ---------------------------------------------------------------------------
module fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT,
  parameter int          IM_WORDS  = 4096,
  parameter int          QDEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault,
  output logic        dbg_state
);

  localparam int            CW           = $clog2(QDEPTH) + 1;
  localparam logic [PC_W:0] WINDOW_BYTES = (PC_W + 1)'(IM_WORDS) << 2;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PC_W-1:0] pc_q, pc_d;
  fetch_state_e    state_q, state_d;
  logic            fault_q;

  // -------------------------------------------------------------------------
  // Queue interface
  // -------------------------------------------------------------------------
  logic               q_clear;
  logic               q_push;
  logic               q_pop;
  logic [CW-1:0]      q_count;
  logic               q_head_valid;
  logic [ENTRY_W-1:0] q_head_data;
  logic [ENTRY_W-1:0] q_push_data;

  logic pc_legal;
  logic redir_legal;

  always_comb begin
    pc_legal    = addr_legal(pc_q, BASE_ADDR, WINDOW_BYTES);
    redir_legal = addr_legal(redirect_pc, BASE_ADDR, WINDOW_BYTES);

    q_pop       = q_head_valid && if_ready;
    q_clear     = redirect_valid;
    // Fetch only while running, not being redirected, from a legal PC, and
    // with a free slot (or one being freed by this cycle's pop).
    q_push      = (state_q == FS_RUN) && !redirect_valid && pc_legal &&
                  ((q_count < CW'(QDEPTH)) || q_pop);
    q_push_data = {pc_q, imem_instr};

    pc_d    = pc_q;
    state_d = state_q;

    if (redirect_valid) begin
      pc_d    = redirect_pc;
      state_d = redir_legal ? FS_RUN : FS_FAULT;
    end else begin
      if (q_push) begin
        pc_d = pc_q + 32'd4;
      end
      // Walking off the window (or landing misaligned) halts fetch; the PC
      // keeps pointing at the offending address.
      if ((state_q == FS_RUN) && !pc_legal) begin
        state_d = FS_FAULT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= BASE_ADDR;
      state_q <= FS_RUN;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      fault_q <= (state_d == FS_FAULT);
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .clear      (q_clear),
    .push       (q_push),
    .push_data  (q_push_data),
    .pop        (q_pop),
    .count      (q_count),
    .head_valid (q_head_valid),
    .head_data  (q_head_data)
  );

  assign imem_pc     = pc_q;
  assign if_valid    = q_head_valid;
  assign if_pc       = q_head_data[ENTRY_W-1:INSTR_W];
  assign if_instr    = q_head_data[INSTR_W-1:0];
  assign fetch_fault = fault_q;
  assign dbg_state   = logic'(state_q);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit: directed + randomized bench for fetch_unit. The reference
// model is a queue of expected {pc, instr} entries plus a model PC and fault
// flag, advanced once per clock from the handshake/redirect rules.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] BASE     = 32'h0000_3000;
  localparam int          IM_WORDS = 4096;
  localparam int          QDEPTH   = 2;

  // -------------------------------------------------------------------------
  // Clock / reset / DUT
  // -------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic        dbg_state;

  always #5 clk = ~clk;

  fetch_unit #(
    .BASE_ADDR (BASE),
    .IM_WORDS  (IM_WORDS),
    .QDEPTH    (QDEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_instr     (imem_instr),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_fault    (fetch_fault),
    .dbg_state      (dbg_state)
  );

  // Instruction memory contents: a fixed scramble of the address, so every
  // word is distinct and the memory needs no preload.
  function automatic logic [31:0] mem_word(logic [31:0] a);
    logic [31:0] x;
    x = a * 32'h9E37_79B1;
    return x ^ (x >> 15) ^ 32'h1357_9BDF;
  endfunction

  assign imem_instr = mem_word(imem_pc);

  // -------------------------------------------------------------------------
  // Reference model and scoreboard
  // -------------------------------------------------------------------------
  logic [63:0] exp_q[$];
  logic [31:0] m_pc;
  logic        m_fault;
  int          checks = 0;
  int          errors = 0;

  function automatic bit ref_legal(logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(BASE);
    return (a % 4 == 0) && (off >= 0) && (off < 4 * IM_WORDS);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pc    = BASE;
    m_fault = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_pc", imem_pc, m_pc);
    chk("if_valid", 32'(if_valid), 32'(exp_q.size() > 0));
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    if (exp_q.size() > 0) begin
      chk("if_pc", if_pc, exp_q[0][63:32]);
      chk("if_instr", if_instr, exp_q[0][31:0]);
    end
  endtask

  // One clock: apply the rules to the current inputs, clock, then compare.
  task automatic step();
    bit pop;
    pop = (exp_q.size() > 0) && if_ready;
    if (redirect_valid) begin
      exp_q.delete();
      m_pc    = redirect_pc;
      m_fault = !ref_legal(redirect_pc);
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (!m_fault) begin
        if (!ref_legal(m_pc)) begin
          m_fault = 1'b1;
        end else if (exp_q.size() < QDEPTH) begin
          exp_q.push_back({m_pc, mem_word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic redirect_step(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  function automatic logic [31:0] rand_target();
    case ($urandom_range(0, 5))
      0: return BASE + 32'(4 * $urandom_range(0, IM_WORDS - 1));
      1: return BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
      2: return 32'($urandom_range(0, int'(BASE) - 1)) & ~32'h3;
      3: return BASE + 32'(4 * IM_WORDS) - 32'(4 * $urandom_range(1, 3));
      4: return BASE + 32'(4 * IM_WORDS);
      default: return BASE + 32'(4 * $urandom_range(0, 31));
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Directed + random sequence
  // -------------------------------------------------------------------------
  initial begin
    int nvalid;
    reset          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_imem_pc", imem_pc, BASE);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Straight-line stream with decode always ready
    if_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_pc", if_pc, BASE + 32'(4 * i));
      chk("stream_instr", if_instr, mem_word(BASE + 32'(4 * i)));
    end

    // Back-pressure from a fresh start at BASE
    if_ready = 1'b0;
    redirect_step(BASE);
    for (int i = 0; i < 5; i++) step();
    chk("stall_imem_pc", imem_pc, BASE + 32'h8);
    chk("stall_if_pc", if_pc, BASE);
    if_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // Redirect with two entries queued and a pop in the same cycle
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) step();
    if_ready = 1'b1;
    redirect_step(32'h0000_3040);
    chk("redir_flush_valid", 32'(if_valid), 32'd0);
    step();
    chk("redir_target_pc", if_pc, 32'h0000_3040);

    // Misaligned redirect faults, legal redirect recovers
    redirect_step(32'h0000_3042);
    chk("misalign_fault", 32'(fetch_fault), 32'd1);
    for (int i = 0; i < 3; i++) step();
    chk("fault_pc_hold", imem_pc, 32'h0000_3042);
    redirect_step(BASE);
    chk("recover_fault", 32'(fetch_fault), 32'd0);
    step();
    chk("recover_pc", if_pc, BASE);

    // Run off the end of the window
    redirect_step(BASE + 32'(4 * IM_WORDS) - 32'd8);
    nvalid = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      nvalid += int'(if_valid);
    end
    chk("eow_words", 32'(nvalid), 32'd2);
    chk("eow_fault", 32'(fetch_fault), 32'd1);

    // Randomized handshake and redirects
    redirect_step(BASE);
    for (int i = 0; i < 400; i++) begin
      if_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) redirect_step(rand_target());
      else step();
      // Make sure a long fault never starves the run of traffic
      if (m_fault && $urandom_range(0, 3) == 0) redirect_step(BASE + 32'(4 * $urandom_range(0, 63)));
    end

    // Asynchronous reset in the middle of a full queue
    if_ready = 1'b0;
    redirect_step(BASE + 32'h100);
    for (int i = 0; i < 3; i++) step();
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("midrst_if_valid", 32'(if_valid), 32'd0);
    chk("midrst_imem_pc", imem_pc, BASE);
    chk("midrst_fault", 32'(fetch_fault), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset    = 1'b1;
    if_ready = 1'b1;
    step();
    chk("midrst_restart_pc", if_pc, BASE);
    for (int i = 0; i < 4; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_unit
